seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It is the successor to the fixed 7-bit sequence-detector FSM. It watches a 1-bit serial stream and pulses z after the last bit of a runtime-programmable pattern of length 1..MAX_LEN. It supports overlapping and non-overlapping detection, sample-enable gating and a saturating match counter. It sits between the serial input synchroniser and the control/status logic.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (>=2).
CNT_W, 8, width of the match counter.
DEF_PAT, 16'b0000000000110011, pattern loaded at reset. Only bits [DEF_LEN-1:0] are used, so the reset pattern is 0110011.
DEF_LEN, 7, pattern length loaded at reset.
Derived localparam: LEN_W = $clog2(MAX_LEN+1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
en  in  1  sample strobe; w is consumed only on cycles with en=1.
w  in  1  serial data bit.
cfg_load  in  1  one-cycle strobe; latches cfg_pat, cfg_len and cfg_overlap.
cfg_pat  in  MAX_LEN  pattern. Bit [len-1] is the first bit received; bit [0] is the last bit received.
cfg_len  in  LEN_W  pattern length.
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
cnt_clr  in  1  synchronous clear of match_cnt.
z  out  1  match pulse, registered.
match_cnt  out  CNT_W  saturating count of matches.
cfg_err  out  1  latched configuration is invalid.

Behaviour:
- Reset (reset=0, async), all registers:
  - pat_r=DEF_PAT, len_r=DEF_LEN, ovl_r=0.
  - hist=0, fill=0.
  - z=0, match_cnt=0, cfg_err=0.
- Registered state:
  - hist[MAX_LEN-1:0]: shift register holding the last sampled bits; newest bit at [0].
  - fill[LEN_W-1:0]: number of valid bits in hist, saturating at MAX_LEN.
- Sample cycle (en=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], w}.
  - fill_n = min(fill+1, MAX_LEN).
- Match condition, evaluated on the sample cycle using the new window:
  - cfg_err=0, fill_n >= len_r, and new_hist[len_r-1:0] == pat_r[len_r-1:0].
  - Detection is true sliding-window. A mismatch never discards a valid partial match that is a suffix of the stream.
- Match response:
  - z=1 in the cycle after the matching sample (latency 1 from the final bit's clock edge).
  - z=1 for exactly one cycle per match.
  - match_cnt increments, saturating at 2^CNT_W-1 (no wrap).
- Overlap mode after a match:
  - ovl_r=1: fill <= fill_n, so the match tail may start the next match.
  - ovl_r=0: fill <= 0, so the next match needs len_r fresh samples.
- en=0: hist and fill hold; z=0 next cycle. Gaps in en do not break a pattern in progress.
- cfg_load=1:
  - Latches pat_r, len_r and ovl_r.
  - Clears hist and fill to 0; z=0 next cycle.
  - w is not sampled that cycle, even if en=1. cfg_load has priority over en.
  - match_cnt is unaffected.
- cfg_err: registered on cfg_load as (cfg_len==0) || (cfg_len>MAX_LEN).
  - While cfg_err=1, no matches occur, but hist and fill continue to update.
- cnt_clr=1: match_cnt <= 0.
  - If a match occurs in the same cycle, clear wins (count=0), but z still pulses.
- Reset mid-pattern: all partial progress is lost; z is driven low immediately.
- Implementation: single clocked always block plus combinational match compare. No latches; every combinational output is fully assigned.

Test Plan:
1. Default pattern:
   - Stimulus: after reset, en=1, stream 0,1,1,0,0,1,1,0.
   - Required: z=1 only in the cycle after the 7th bit; match_cnt=1; cfg_err=0.
2. Overlapping mode:
   - Stimulus: cfg_load pat=...101, len=3, overlap=1; stream 1,0,1,0,1.
   - Required: z pulses after bits 3 and 5; match_cnt=2.
   - Repeat with overlap=0: one pulse, after bit 3 only; match_cnt=1.
3. Enable gaps:
   - Stimulus: len=3 pattern 110; stream 1,(en=0 for 4 cycles),1,0.
   - Required: one z pulse after the final 0; z=0 throughout the gap.
4. Invalid length:
   - Stimulus: cfg_load with len=0, then with len=MAX_LEN+1; stream containing the pattern.
   - Required: cfg_err=1 and z never asserts in both cases.
   - Then a valid cfg_load: cfg_err=0.
5. Counter saturation and clear (CNT_W=2):
   - Stimulus: 5 matches; then cnt_clr asserted in the same cycle as a 6th match.
   - Required: match_cnt stops at 3 after 5 matches.
   - On the 6th match: match_cnt=0 and z=1.
6. Reset and mid-stream reconfiguration:
   - Stimulus: assert reset after 5 bits of the default pattern; release; send the remaining 2 bits.
   - Required: no z pulse.
   - Stimulus: cfg_load mid-pattern.
   - Required: fill restarts at 0; no spurious match.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-programmable pattern and length.
// Supports overlapping or non-overlapping matching and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(16'b0000000000110011),
  parameter int unsigned DEF_LEN = 7,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               w,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               z_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               sample;
  logic               match;

  // Compare only the low len_q bits of the window that includes the current bit.
  always_comb begin
    sample   = en && !cfg_load;
    hist_d   = {hist_q[MAX_LEN-2:0], w};
    fill_d   = (fill_q == MaxLenW) ? fill_q : fill_q + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = sample && !err_q && (fill_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      z_q <= match;
      if (cfg_load) begin
        pat_q  <= cfg_pat;
        len_q  <= cfg_len;
        ovl_q  <= cfg_overlap;
        err_q  <= (cfg_len == '0) || (cfg_len > MaxLenW);
        hist_q <= '0;
        fill_q <= '0;
      end else if (en) begin
        hist_q <= hist_d;
        fill_q <= (match && !ovl_q) ? '0 : fill_d;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (match && cnt_q != CntMax) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: expected z per sample is queued when driven
// and compared after the following clock edge; the match count is modelled alongside.
module tb_seq_detect_param;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned CntW   = 2;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);

  logic              clk;
  logic              reset;
  logic              en;
  logic              w;
  logic              cfg_load;
  logic [MaxLen-1:0] cfg_pat;
  logic [LenW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic              cnt_clr;
  logic              z;
  logic [CntW-1:0]   match_cnt;
  logic              cfg_err;

  int   n_tests;
  int   n_fail;
  int   exp_cnt;
  logic exp_q[$];

  seq_detect_param #(
    .MAX_LEN(MaxLen),
    .CNT_W  (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .w          (w),
    .cfg_load   (cfg_load),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .z          (z),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, queue the expected z, then compare after the edge.
  task automatic cycle(input logic e, input logic b, input logic ld, input logic clr,
                       input logic exp_z);
    logic exp_v;
    @(negedge clk);
    en = e; w = b; cfg_load = ld; cnt_clr = clr;
    exp_q.push_back(exp_z);
    if (clr) exp_cnt = 0;
    else if (exp_z && exp_cnt != 3) exp_cnt++;
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check_eq("z", {31'd0, z}, {31'd0, exp_v});
    en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  // Send n bits MSB first with en=1; exp holds the expected z for each bit, same order.
  task automatic send(input logic [31:0] bits, input int n, input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0, 1'b0, exp[i]);
  endtask

  // Loads with en=1 and w=1 so a wrongly consumed bit would show up later.
  task automatic load(input logic [MaxLen-1:0] pat, input logic [LenW-1:0] len,
                      input logic ovl);
    cfg_pat = pat; cfg_len = len; cfg_overlap = ovl;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_cnt();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = 0;
    reset = 1'b0; en = 1'b0; w = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
    #12;
    check_eq("rst_z", {31'd0, z}, 0);
    check_eq("rst_cnt", {30'd0, match_cnt}, 0);
    check_eq("rst_err", {31'd0, cfg_err}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Default pattern 0110011, one trailing bit.
    send(32'b01100110, 8, 32'b00000010);
    check_eq("t1_cnt", {30'd0, match_cnt}, 32'(exp_cnt));
    check_eq("t1_cnt_abs", {30'd0, match_cnt}, 1);
    check_eq("t1_err", {31'd0, cfg_err}, 0);

    // Overlapping 101.
    clear_cnt();
    load(16'b101, 5'd3, 1'b1);
    send(32'b10101, 5, 32'b00101);
    check_eq("t2_ovl_cnt", {30'd0, match_cnt}, 2);

    // Non-overlapping 101.
    clear_cnt();
    load(16'b101, 5'd3, 1'b0);
    send(32'b10101, 5, 32'b00100);
    check_eq("t2_novl_cnt", {30'd0, match_cnt}, 1);

    // Enable gap inside pattern 110.
    clear_cnt();
    load(16'b110, 5'd3, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'b10, 2, 32'b01);
    check_eq("t3_cnt", {30'd0, match_cnt}, 1);

    // Invalid lengths: zero, then MAX_LEN+1.
    clear_cnt();
    load(16'b0, 5'd0, 1'b1);
    check_eq("t4_err_len0", {31'd0, cfg_err}, 1);
    send(32'b1010011, 7, 32'b0);
    load(16'hFFFF, 5'(MaxLen + 1), 1'b1);
    check_eq("t4_err_len17", {31'd0, cfg_err}, 1);
    send(32'h3FFFF, 18, 32'b0);
    check_eq("t4_cnt", {30'd0, match_cnt}, 0);
    load(16'b101, 5'd3, 1'b1);
    check_eq("t4_err_clr", {31'd0, cfg_err}, 0);

    // Saturation with a 1-bit pattern, then clear racing a sixth match.
    clear_cnt();
    load(16'b1, 5'd1, 1'b1);
    send(32'b11111, 5, 32'b11111);
    check_eq("t5_sat", {30'd0, match_cnt}, 3);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("t5_clr_win", {30'd0, match_cnt}, 0);

    // Reset drops z immediately while a pulse is showing.
    load(16'b0110011, 5'd7, 1'b0);
    send(32'b0110011, 7, 32'b0000001);
    reset = 1'b0;
    #1;
    check_eq("t6_async_z", {31'd0, z}, 0);
    check_eq("t6_async_cnt", {30'd0, match_cnt}, 0);
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b1;

    // Reset after 5 bits loses progress.
    send(32'b01100, 5, 32'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send(32'b11, 2, 32'b0);

    // Reload mid-pattern restarts the window; a full pattern afterwards still matches.
    send(32'b01100, 5, 32'b0);
    load(16'b0110011, 5'd7, 1'b0);
    send(32'b110110011, 9, 32'b000000001);
    check_eq("t6_cnt", {30'd0, match_cnt}, 32'(exp_cnt));
    check_eq("t6_err", {31'd0, cfg_err}, 0);
    check_eq("sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
